uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync.sv | 22 ++
 rtl/uart_rx_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync (
    input  logic clk_in,
    input  logic rst_in,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Two-stage capture to settle metastability before the FSM sees the line.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            meta     <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: oversampled start/data/stop decoding with a one-entry output buffer.
// Optional macro UART_RX_MAJORITY_EN switches bit decisions to a 3-sample majority vote
// around the bit center; the default build uses a single center sample.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 sample_tick_in,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 frame_err_out,
    output logic                 overrun_err_out,
    output logic                 busy_out
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    logic                 rxs;
    rx_state_t            state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [BIT_W-1:0]     bit_cnt, bit_nx;
    logic [DATA_BITS-1:0] shreg, sh_nx;
    logic                 armed, armed_nx;
    logic                 byte_done, frame_bad;
    logic                 dec_hit, last_hit, bit_val;

    uart_sync u_sync (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .async_in (rx_in),
        .sync_out (rxs)
    );

    assign last_hit = (cnt == CNT_W'(OVERSAMPLE - 1));
    assign busy_out = (state != IDLE);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote;

    // Capture the two samples preceding the decision tick for the vote.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vote <= 2'b00;
        end else if (sample_tick_in) begin
            if (cnt == CNT_W'(OVERSAMPLE/2 - 1)) vote[0] <= rxs;
            if (cnt == CNT_W'(OVERSAMPLE/2))     vote[1] <= rxs;
        end
    end

    assign dec_hit = (cnt == CNT_W'(OVERSAMPLE/2 + 1));
    assign bit_val = (vote[0] & vote[1]) | (vote[0] & rxs) | (vote[1] & rxs);
`else
    assign dec_hit = (cnt == CNT_W'(OVERSAMPLE/2));
    assign bit_val = rxs;
`endif

    // Next-state logic: everything advances only on sample ticks.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        bit_nx    = bit_cnt;
        sh_nx     = shreg;
        armed_nx  = armed;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        if (sample_tick_in) begin
            if (rxs) armed_nx = 1'b1;
            case (state)
                IDLE: begin
                    cnt_nx = '0;
                    if (!rxs && armed) state_nx = START;
                end
                START: begin
                    cnt_nx = cnt + 1'b1;
                    if (dec_hit && bit_val) begin
                        // Line went back high: glitch, not a start bit.
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (last_hit) begin
                        cnt_nx   = '0;
                        bit_nx   = '0;
                        state_nx = DATA;
                    end
                end
                DATA: begin
                    cnt_nx = cnt + 1'b1;
                    if (dec_hit) sh_nx = {bit_val, shreg[DATA_BITS-1:1]};
                    if (last_hit) begin
                        cnt_nx = '0;
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            bit_nx   = '0;
                            state_nx = STOP;
                        end else begin
                            bit_nx = bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    cnt_nx = cnt + 1'b1;
                    if (dec_hit) begin
                        // Return early so the next start edge is not missed.
                        state_nx = IDLE;
                        cnt_nx   = '0;
                        if (bit_val) begin
                            byte_done = 1'b1;
                        end else begin
                            // Disarm so a stuck-low line cannot start a new frame.
                            frame_bad = 1'b1;
                            armed_nx  = 1'b0;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            armed   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_cnt <= bit_nx;
            shreg   <= sh_nx;
            armed   <= armed_nx;
        end
    end

    // Output buffer, handshake and registered error pulses, evaluated every cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            data_out        <= '0;
            valid_out       <= 1'b0;
            frame_err_out   <= 1'b0;
            overrun_err_out <= 1'b0;
        end else begin
            frame_err_out   <= frame_bad;
            overrun_err_out <= 1'b0;
            if (byte_done && (!valid_out || ready_in)) begin
                data_out  <= shreg;
                valid_out <= 1'b1;
            end else begin
                if (byte_done)              overrun_err_out <= 1'b1;
                if (valid_out && ready_in) valid_out       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl; honours UART_RX_MAJORITY_EN for decision timing.
module tb_uart_rx_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       sample_tick_in;
    logic       rx_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in;
    logic       frame_err_out;
    logic       overrun_err_out;
    logic       busy_out;

    int n_tests = 0;
    int n_fail  = 0;
    int fe_cnt  = 0;
    int ov_cnt  = 0;
    int vld_cnt = 0;

    // Tick index within a bench bit (tick 0 = first tick of the bit) of the stop decision.
`ifdef UART_RX_MAJORITY_EN
    localparam int DEC = 10;
`else
    localparam int DEC = 9;
`endif

    uart_rx_ctrl #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_tick_in  (sample_tick_in),
        .rx_in           (rx_in),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .ready_in        (ready_in),
        .frame_err_out   (frame_err_out),
        .overrun_err_out (overrun_err_out),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Count output events once per cycle.
    always @(negedge clk_in) begin
        if (frame_err_out)   fe_cnt++;
        if (overrun_err_out) ov_cnt++;
        if (valid_out)       vld_cnt++;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One sample tick; returns at the negedge right after the tick edge.
    task automatic tick();
        repeat (3) @(negedge clk_in);
        @(negedge clk_in) sample_tick_in = 1'b1;
        @(negedge clk_in) sample_tick_in = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        ticks(n);
    endtask

    // Frame up to and including the stop decision tick; optional one-tick glitch
    // at the center of data bit gbit.
    task automatic send(input logic [7:0] d, input logic stop, input int gbit);
        rx_in = 1'b0;
        ticks(16);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 16; j++) begin
                rx_in = (k == gbit && j == 9) ? ~d[k] : d[k];
                tick();
            end
        end
        rx_in = stop;
        for (int j = 0; j <= DEC; j++) tick();
    endtask

    initial begin
        int vsnap;
        rst_in = 1'b1; rx_in = 1'b0; ready_in = 1'b1; sample_tick_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk8("rst_data", data_out, 8'h00);
        chk1("rst_valid", valid_out, 1'b0);
        chk1("rst_ferr", frame_err_out, 1'b0);
        chk1("rst_ovr", overrun_err_out, 1'b0);
        chk1("rst_busy", busy_out, 1'b0);
        rst_in = 1'b0;

        // Line low straight out of reset: not armed, no start.
        ticks(3);
        chk1("unarmed_busy", busy_out, 1'b0);
        idle(4);

        // 0xA5 with ready high: one-cycle valid right after the stop decision.
        send(8'hA5, 1'b1, -1);
        chk1("a5_valid", valid_out, 1'b1);
        chk8("a5_data", data_out, 8'hA5);
        @(negedge clk_in);
        chk1("a5_valid_1cyc", valid_out, 1'b0);
        idle(20);

        // 0x3C then 0xC3 without consumer: second byte dropped with overrun.
        ready_in = 1'b0;
        send(8'h3C, 1'b1, -1);
        chk1("3c_valid", valid_out, 1'b1);
        chk8("3c_data", data_out, 8'h3C);
        idle(20);
        send(8'hC3, 1'b1, -1);
        chk1("ovr_pulse", overrun_err_out, 1'b1);
        chk8("ovr_data_kept", data_out, 8'h3C);
        chk1("ovr_valid_held", valid_out, 1'b1);
        @(negedge clk_in);
        chk1("ovr_pulse_end", overrun_err_out, 1'b0);
        chki("ovr_count", ov_cnt, 1);
        ready_in = 1'b1;
        @(negedge clk_in);
        chk1("ovr_drain", valid_out, 1'b0);
        idle(20);

        // 0x55 with a low stop bit, then a stuck-low line.
        send(8'h55, 1'b0, -1);
        chk1("ferr_pulse", frame_err_out, 1'b1);
        chk1("ferr_valid", valid_out, 1'b0);
        @(negedge clk_in);
        chk1("ferr_pulse_end", frame_err_out, 1'b0);
        ticks(40);
        chk1("ferr_no_rearm", busy_out, 1'b0);
        chki("ferr_count", fe_cnt, 1);
        idle(4);
        send(8'h81, 1'b1, -1);
        chk8("after_ferr_data", data_out, 8'h81);
        chk1("after_ferr_valid", valid_out, 1'b1);
        idle(20);

        // False start: low for 4 ticks then high.
        vsnap = vld_cnt;
        rx_in = 1'b0;
        ticks(4);
        chk1("fs_busy", busy_out, 1'b1);
        rx_in = 1'b1;
        ticks(DEC + 1 - 4);
        chk1("fs_idle", busy_out, 1'b0);
        idle(20);
        chki("fs_no_valid", vld_cnt, vsnap);
        chki("fs_no_ferr", fe_cnt, 1);

        // Reset during bit 3 of 0xFF, then 0x12.
        rx_in = 1'b0;
        ticks(16);
        rx_in = 1'b1;
        ticks(48 + 5);
        chk1("pre_rst_busy", busy_out, 1'b1);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        chk1("mid_rst_busy", busy_out, 1'b0);
        idle(200);
        chki("abort_no_valid", vld_cnt, vsnap);
        chki("abort_no_ferr", fe_cnt, 1);
        chki("abort_no_ovr", ov_cnt, 1);
        send(8'h12, 1'b1, -1);
        chk8("post_rst_data", data_out, 8'h12);
        chk1("post_rst_valid", valid_out, 1'b1);
        idle(20);

        // One-tick inversion at the center of bit 0 of 0x0F.
        send(8'h0F, 1'b1, 0);
`ifdef UART_RX_MAJORITY_EN
        chk8("glitch_data", data_out, 8'h0F);
`else
        chk8("glitch_data", data_out, 8'h0E);
`endif
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
